echo_delay_engine: RTL and testbench

- Parametrised successor to the single-tap echo processor.
- Captures offset-binary ADC samples on a `data_valid` rising edge and runs a sequenced read/compute/write cycle against an internal circular delay RAM.
- Emits offset-binary DAC samples.
- Adds runtime-selectable mode (bypass / feedforward echo / feedback comb), a programmable gain shift, saturating arithmetic, a warm-up fill guard and overrun detection.

---
 rtl/echo_delay_engine.sv | 133 +++++++++++++
 tb/tb_echo_delay_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_engine.sv
// Single-tap echo processor: offset-binary samples pass through a circular delay RAM
// with bypass, feedforward-echo or feedback-comb processing and saturating arithmetic.
module echo_delay_engine #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 13,
    parameter int OFFSET = 512
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [ADDR_W-1:0] delay,
    input  logic [1:0]        mode,
    input  logic [1:0]        gain_shift,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE} state_t;
    typedef enum logic [1:0] {M_BYPASS = 2'b00, M_FF = 2'b01, M_FB = 2'b10, M_RSVD = 2'b11} mode_t;

    localparam logic [DATA_W-1:0] OFF      = OFFSET[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W:0]   FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t                    state_q;
    mode_t                     mode_q;
    logic                      dv_q;
    logic signed [DATA_W-1:0]  x_q, y_q, ram_q;
    logic [ADDR_W-1:0]         d_q, wptr_q, rd_addr_q;
    logic [ADDR_W:0]           fill_q;
    logic [1:0]                gs_q;
    logic [DATA_W-1:0]         data_out_q;
    logic                      out_valid_q, overrun_q;

    logic [DATA_W-1:0]         mem [2**ADDR_W];

    logic                      start_d;
    logic signed [DATA_W-1:0]  t_d, tap_d, y_d;
    logic signed [DATA_W:0]    sum_d;
    logic [2:0]                shamt_d;

    assign start_d = data_valid & ~dv_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        t_d     = '0;
        shamt_d = {1'b0, gs_q} + 3'd1;
        sum_d   = {x_q[DATA_W-1], x_q};
        y_d     = x_q;
        // Fill guard: a tap reaching past the samples written since reset contributes zero.
        if ({1'b0, d_q} <= fill_q)
            t_d = ram_q;
        tap_d = t_d >>> shamt_d;
        case (mode_q)
            M_FF:    sum_d = {x_q[DATA_W-1], x_q} + {tap_d[DATA_W-1], tap_d};
            M_FB:    sum_d = {x_q[DATA_W-1], x_q} - {tap_d[DATA_W-1], tap_d};
            default: sum_d = {x_q[DATA_W-1], x_q};
        endcase
        if (sum_d[DATA_W] != sum_d[DATA_W-1])
            y_d = sum_d[DATA_W] ? SAT_MIN : SAT_MAX;
        else
            y_d = sum_d[DATA_W-1:0];
    end

    // NOTE: the delay RAM is deliberately not reset; the fill guard masks stale contents.
    always_ff @(posedge sysclk) begin
        if (state_q == S_WRITE && !rst)
            mem[wptr_q] <= (mode_q == M_FB) ? y_q : x_q;
        if (state_q == S_WAIT)
            ram_q <= mem[rd_addr_q];
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= M_BYPASS;
            dv_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            d_q         <= '0;
            gs_q        <= '0;
            wptr_q      <= '0;
            rd_addr_q   <= '0;
            fill_q      <= '0;
            data_out_q  <= OFF;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dv_q        <= data_valid;
            out_valid_q <= 1'b0;
            if (start_d && state_q != S_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: if (start_d) begin
                    x_q     <= data_in - OFF;
                    d_q     <= (delay == '0) ? ADDR_W'(1) : delay;
                    mode_q  <= mode_t'(mode);
                    gs_q    <= gain_shift;
                    state_q <= S_READ;
                end
                S_READ: begin
                    rd_addr_q <= wptr_q - d_q;
                    state_q   <= S_WAIT;
                end
                S_WAIT: state_q <= S_CALC;
                S_CALC: begin
                    // Output registered here so data_out and out_valid coincide in WRITE.
                    y_q         <= y_d;
                    data_out_q  <= y_d + OFF;
                    out_valid_q <= 1'b1;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    wptr_q  <= wptr_q + 1'b1;
                    if (fill_q != FILL_MAX)
                        fill_q <= fill_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay_engine.sv
// Self-checking bench for echo_delay_engine: directed vector table, hand-written corner
// sequences and randomized samples scored against an arithmetic reference model.
module tb_echo_delay_engine;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 13;
    localparam int OFFSET = 512;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              sysclk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_valid = 1'b0;
    logic [ADDR_W-1:0] delay = '0;
    logic [1:0]        mode = '0;
    logic [1:0]        gain_shift = '0;
    logic [DATA_W-1:0] data_out;
    logic              out_valid, busy, overrun;

    echo_delay_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFFSET(OFFSET)) dut (
        .sysclk(sysclk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .delay(delay), .mode(mode), .gain_shift(gain_shift), .data_out(data_out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int failures = 0;

    // Reference model: sample history with a written-since-reset flag per location.
    int m_mem [DEPTH];
    bit m_written [DEPTH];
    int m_wptr;

    typedef struct {
        bit rst_before;
        int din, dly, md, gs, exp_out;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0;
        for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
    endtask

    task automatic model_step(input int x, input int dly, input int md, input int gs, output int y);
        int d, addr, t, k, tap, s;
        d    = (dly == 0) ? 1 : dly;
        addr = (m_wptr - d + DEPTH) % DEPTH;
        t    = m_written[addr] ? m_mem[addr] : 0;
        k    = 1 << (gs + 1);
        tap  = (t >= 0) ? t / k : -((-t + k - 1) / k);
        case (md)
            1:       s = x + tap;
            2:       s = x - tap;
            default: s = x;
        endcase
        if (s > OFFSET - 1) s = OFFSET - 1;
        if (s < -OFFSET)    s = -OFFSET;
        y = s;
        m_mem[m_wptr]     = (md == 2) ? s : x;
        m_written[m_wptr] = 1'b1;
        m_wptr            = (m_wptr + 1) % DEPTH;
    endtask

    task automatic do_reset();
        @(posedge sysclk); #1;
        rst = 1'b1;
        data_valid = 1'b0;
        repeat (2) @(posedge sysclk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk); #1;
        end
    endtask

    // Called just after a rising edge; raises data_valid and follows the sample for 5 cycles.
    task automatic apply(input int din, input int dly, input int md, input int gs,
                         input int hold, input string tag, output int got);
        int exp_y, ov_cnt, ov_pos, busy_mask;
        data_in    = DATA_W'(din);
        delay      = ADDR_W'(dly);
        mode       = 2'(md);
        gain_shift = 2'(gs);
        data_valid = 1'b1;
        model_step(din - OFFSET, dly, md, gs, exp_y);
        ov_cnt = 0; ov_pos = 0; busy_mask = 0; got = -1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge sysclk); #1;
            if (i == hold) data_valid = 1'b0;
            if (i == 1) begin
                data_in    = DATA_W'($urandom);
                delay      = ADDR_W'($urandom);
                mode       = 2'($urandom);
                gain_shift = 2'($urandom);
            end
            busy_mask[i-1] = busy;
            if (out_valid === 1'b1) begin
                ov_cnt++;
                ov_pos = i;
                got = int'(data_out);
            end
        end
        check({tag, " pulses"}, ov_cnt, 1);
        check({tag, " latency"}, ov_pos, 4);
        check({tag, " data_out"}, got, exp_y + OFFSET);
        check({tag, " busy"}, busy_mask, 5'b01111);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, cnt, din, dly, r;

        tbl[0]  = '{1, 700,  0, 0, 0, 700};
        tbl[1]  = '{1, 712,  3, 1, 0, 712};
        tbl[2]  = '{0, 512,  3, 1, 0, 512};
        tbl[3]  = '{0, 512,  3, 1, 0, 512};
        tbl[4]  = '{0, 512,  3, 1, 0, 612};
        tbl[5]  = '{0, 512,  3, 1, 0, 512};
        tbl[6]  = '{1, 712,  1, 2, 0, 712};
        tbl[7]  = '{0, 512,  1, 2, 0, 412};
        tbl[8]  = '{0, 512,  1, 2, 0, 562};
        tbl[9]  = '{0, 512,  1, 2, 0, 487};
        tbl[10] = '{1, 1023, 1, 1, 0, 1023};
        tbl[11] = '{0, 1023, 1, 1, 0, 1023};
        tbl[12] = '{0, 1023, 1, 1, 0, 1023};
        tbl[13] = '{1, 0,    1, 1, 0, 0};
        tbl[14] = '{0, 0,    1, 1, 0, 0};
        tbl[15] = '{1, 712,  0, 1, 0, 712};
        tbl[16] = '{0, 512,  0, 1, 0, 612};
        tbl[17] = '{1, 600,  1, 3, 0, 600};
        tbl[18] = '{0, 512,  1, 3, 0, 512};

        model_reset();
        repeat (3) @(posedge sysclk);
        #1 rst = 1'b0;
        idle(10);
        check("reset data_out", data_out, OFFSET);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].rst_before) do_reset();
            idle(3);
            apply(tbl[i].din, tbl[i].dly, tbl[i].md, tbl[i].gs, 2, $sformatf("vec%0d", i), got);
            check($sformatf("vec%0d table", i), got, tbl[i].exp_out);
        end

        // Second edge two cycles after the first: dropped, sticky overrun, first sample intact.
        do_reset();
        idle(2);
        data_in = 10'd812; delay = 13'd1; mode = 2'd0; gain_shift = 2'd0; data_valid = 1'b1;
        model_step(812 - OFFSET, 1, 0, 0, r);
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge sysclk); #1;
            if (i == 1) data_valid = 1'b0;
            if (i == 2) data_valid = 1'b1;
            if (i == 3) begin
                data_valid = 1'b0;
                check("overrun set", overrun, 1);
            end
            if (i == 4) check("overrun first data_out", data_out, r + OFFSET);
            if (out_valid === 1'b1) cnt++;
        end
        check("overrun single output", cnt, 1);
        apply(300, 1, 1, 0, 2, "after overrun", got);
        check("overrun sticky", overrun, 1);

        // Reset during WAIT discards the sample and restores pointer and fill state.
        do_reset();
        idle(2);
        apply(612, 1, 0, 0, 2, "pre-rst", got);
        idle(2);
        data_in = 10'd900; delay = 13'd1; mode = 2'd1; gain_shift = 2'd0; data_valid = 1'b1;
        cnt = 0;
        @(posedge sysclk); #1;
        data_valid = 1'b0;
        @(posedge sysclk); #1;
        rst = 1'b1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            if (out_valid === 1'b1) cnt++;
            @(posedge sysclk); #1;
        end
        check("mid-rst no out_valid", cnt, 0);
        check("mid-rst data_out", data_out, OFFSET);
        check("mid-rst busy", busy, 0);
        apply(700, 1, 1, 0, 2, "post-rst a", got);
        check("post-rst no tap", got, 700);
        apply(512, 1, 1, 0, 2, "post-rst b", got);
        check("post-rst tap", got, 606);

        // data_valid held high yields exactly one capture.
        idle(2);
        apply(450, 2, 1, 1, 0, "held", got);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge sysclk); #1;
            if (out_valid === 1'b1) cnt++;
        end
        data_valid = 1'b0;
        check("held extra outputs", cnt, 0);

        // Randomized samples against the reference model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            din = (r == 0) ? 0 : (r == 1) ? 1023 : $urandom_range(0, 1023);
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 12);
            apply(din, dly, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4),
                  $sformatf("rnd%0d", n), got);
        end
        check("rnd no overrun", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
